jk_updown_counter: RTL and testbench

- Synchronous modulo-MOD up/down counter built from per-bit JK storage cells.
- Consumes the JK flip-flop primitive downstream. Each bit's next state is J&~Q | ~K&Q, with J/K driven by counter logic.
- Provides the team's first multi-bit JK-based sequential block with load, wrap and terminal-count support.
- Feeds later clock-divider and sequencing stages.

---
 rtl/jk_updown_counter.sv | 141 ++++++++++++++
 tb/tb_jk_updown_counter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/jk_updown_counter.sv
// ----------------------------------------------------------------------------
// jk_updown_counter
//   Synchronous modulo-MOD up/down counter. Every bit is a JK storage cell; the
//   counter logic only steers J/K, the cells never see a direct D value.
//
//   Ports
//     clk       rising-edge clock
//     rst_n     synchronous active-low reset (overrides load and en)
//     en        count enable
//     up        1 = increment, 0 = decrement
//     load      parallel load request (beats en)
//     load_val  value to load; values >= MOD are rejected
//     q         counter value (registered)
//     q_        complement rail of every cell (always ~q)
//     tc        terminal count (combinational): current state wraps next edge
//     load_err  one-cycle registered pulse after a rejected load
// ----------------------------------------------------------------------------

// Single JK storage cell: q_next = J&~Q | ~K&Q.
module jk_cell (
    input  logic clk,
    input  logic i_j,
    input  logic i_k,
    output logic o_q,
    output logic o_qn
);
    logic r_q;

    always_ff @(posedge clk) begin
        r_q <= (i_j & ~r_q) | (~i_k & r_q);
    end

    assign o_q  = r_q;
    assign o_qn = ~r_q;
endmodule

module jk_updown_counter #(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_,
    output logic             tc,
    output logic             load_err
);
    generate
        if (WIDTH < 1 || MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_param
            $error("jk_updown_counter: need WIDTH>=1 and 2 <= MOD <= 2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qn;
    logic [WIDTH-1:0] w_up_t;   // bit i toggles on increment when all lower bits are 1
    logic [WIDTH-1:0] w_dn_t;   // bit i toggles on decrement when all lower bits are 0
    logic             w_ld_ok;
    logic             w_at_max;
    logic             w_at_zero;
    logic             r_load_err;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            jk_cell u_cell (
                .clk  (clk),
                .i_j  (w_j[gi]),
                .i_k  (w_k[gi]),
                .o_q  (w_q[gi]),
                .o_qn (w_qn[gi])
            );
        end
    endgenerate

    assign w_ld_ok   = ({1'b0, load_val} < MOD_W);
    assign w_at_max  = (w_q == MAX_V);
    assign w_at_zero = (w_q == '0);

    always_comb begin
        w_up_t    = '0;
        w_dn_t    = '0;
        w_up_t[0] = 1'b1;
        w_dn_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            w_up_t[i] = w_up_t[i-1] & w_q[i-1];
            w_dn_t[i] = w_dn_t[i-1] & ~w_q[i-1];
        end
    end

    // J/K steering. Default J=K=0 is "hold" for every cell.
    always_comb begin
        w_j = '0;
        w_k = '0;
        if (!rst_n) begin
            w_k = '1;                       // clear every cell
        end else if (load) begin
            if (w_ld_ok) begin
                w_j = load_val;
                w_k = ~load_val;
            end
        end else if (en) begin
            if (up) begin
                if (w_at_max) begin
                    w_k = w_q;              // reset only the set bits -> 0
                end else begin
                    w_j = w_up_t;
                    w_k = w_up_t;
                end
            end else begin
                if (w_at_zero) begin
                    w_j = MAX_V;            // all cells are 0, so J alone sets MOD-1
                end else begin
                    w_j = w_dn_t;
                    w_k = w_dn_t;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= load & ~w_ld_ok;
        end
    end

    assign q        = w_q;
    assign q_       = w_qn;
    assign load_err = r_load_err;
    assign tc       = en & ~load & ((up & w_at_max) | (~up & w_at_zero));
endmodule

// File: tb/tb_jk_updown_counter.sv
module tb_jk_updown_counter;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: WIDTH=4, MOD=10
    logic       rst_n, en, up, load;
    logic [3:0] load_val;
    logic [3:0] q, q_n;
    logic       tc, load_err;

    // DUT B: WIDTH=3, MOD=8 (full modulus)
    logic       b_rst_n, b_en, b_up, b_load;
    logic [2:0] b_load_val;
    logic [2:0] b_q, b_qn;
    logic       b_tc, b_err;

    jk_updown_counter #(.WIDTH(4), .MOD(10)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .q(q), .q_(q_n), .tc(tc), .load_err(load_err)
    );

    jk_updown_counter #(.WIDTH(3), .MOD(8)) u_b (
        .clk(clk), .rst_n(b_rst_n), .en(b_en), .up(b_up), .load(b_load),
        .load_val(b_load_val), .q(b_q), .q_(b_qn), .tc(b_tc), .load_err(b_err)
    );

    int checks = 0;
    int errors = 0;
    int ma_q, mb_q;
    bit ma_err, mb_err;

    // Reference: counter value as plain modular arithmetic.
    function automatic int f_next(int cur, bit r, bit ld, int lv, bit e, bit u, int mod);
        if (!r)      return 0;
        if (ld)      return (lv < mod) ? lv : cur;
        if (!e)      return cur;
        return u ? (cur + 1) % mod : (cur + mod - 1) % mod;
    endfunction

    function automatic bit f_tc(int cur, bit ld, bit e, bit u, int mod);
        return e && !ld && ((u && cur == mod - 1) || (!u && cur == 0));
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc_a(bit r, bit ld, int lv, bit e, bit u, bit ctc);
        @(negedge clk);
        rst_n = r; load = ld; load_val = lv[3:0]; en = e; up = u;
        #1;
        if (ctc) chk("tc_a", {31'b0, tc}, {31'b0, f_tc(ma_q, ld, e, u, 10)});
        @(posedge clk);
        ma_err = r && ld && (lv >= 10);
        ma_q   = f_next(ma_q, r, ld, lv, e, u, 10);
        #1;
        chk("q_a",   {28'b0, q},   ma_q);
        chk("qn_a",  {28'b0, q_n}, {28'b0, ~ma_q[3:0]});
        chk("err_a", {31'b0, load_err}, {31'b0, ma_err});
    endtask

    task automatic cyc_b(bit r, bit ld, int lv, bit e, bit u, bit ctc);
        @(negedge clk);
        b_rst_n = r; b_load = ld; b_load_val = lv[2:0]; b_en = e; b_up = u;
        #1;
        if (ctc) chk("tc_b", {31'b0, b_tc}, {31'b0, f_tc(mb_q, ld, e, u, 8)});
        @(posedge clk);
        mb_err = 1'b0;  // 3-bit load_val can never reach 8
        mb_q   = f_next(mb_q, r, ld, lv, e, u, 8);
        #1;
        chk("q_b",   {29'b0, b_q},  mb_q);
        chk("qn_b",  {29'b0, b_qn}, {29'b0, ~mb_q[2:0]});
        chk("err_b", {31'b0, b_err}, {31'b0, mb_err});
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; load_val = '0;
        b_rst_n = 1'b0; b_en = 1'b0; b_up = 1'b1; b_load = 1'b0; b_load_val = '0;
        ma_q = 0; mb_q = 0; ma_err = 0; mb_err = 0;

        // Reset for two cycles with en=1, up=1; q unknown before first edge
        cyc_a(0, 0, 0, 1, 1, 0);
        cyc_a(0, 0, 0, 1, 1, 1);
        chk("rst_qn", {28'b0, q_n}, 32'hF);

        // Up count with wrap: 1..9,0,1,2
        for (int i = 0; i < 12; i++) cyc_a(1, 0, 0, 1, 1, 1);
        chk("up_end", {28'b0, q}, 32'd2);

        // Down count with wrap: 2,1,0,9,8
        cyc_a(1, 1, 2, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc_a(1, 0, 0, 1, 0, 1);
        chk("dn_end", {28'b0, q}, 32'd8);

        // Load beats en, then rejected load holds and pulses load_err once
        cyc_a(1, 1, 7, 1, 1, 1);
        chk("ld_pri", {28'b0, q}, 32'd7);
        cyc_a(1, 1, 12, 1, 1, 1);
        chk("ld_rej", {31'b0, load_err}, 32'd1);
        cyc_a(1, 0, 0, 0, 1, 1);
        chk("err_clr", {31'b0, load_err}, 32'd0);

        // Hold at 5 with complement 4'hA
        cyc_a(1, 1, 5, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            cyc_a(1, 0, 0, 0, i[0], 1);
            chk("hold_qn", {28'b0, q_n}, 32'hA);
        end

        // Reset wins over a same-cycle load
        cyc_a(1, 1, 4, 0, 1, 1);
        cyc_a(0, 1, 3, 1, 1, 1);
        chk("rst_ld", {28'b0, q}, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc_a(($urandom_range(0, 31) != 0),
                  ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 1) == 1, 1);
        end

        // Full modulus: natural overflow / underflow
        mb_q = 0;
        cyc_b(0, 0, 0, 0, 1, 0);
        cyc_b(1, 1, 7, 0, 1, 1);
        cyc_b(1, 0, 0, 1, 1, 1);
        chk("b_ovf", {29'b0, b_q}, 32'd0);
        cyc_b(1, 0, 0, 1, 0, 1);
        chk("b_udf", {29'b0, b_q}, 32'd7);
        for (int i = 0; i < 100; i++) begin
            cyc_b(($urandom_range(0, 31) != 0),
                  ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 1) == 1, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
